keygen_mul_pipe: RTL and testbench

Parametrised, elastic pipelined multiplier for the keygen datapath. It replaces the fixed-width, `ce`-gated multiplier instances with one block that has:
- configurable operand widths, signedness and pipeline depth;
- a valid/ready handshake with per-stage bubble collapsing;
- a sideband tag that travels with each product.

It sits between keygen polynomial-arithmetic stages that must tolerate downstream back-pressure.

---
 rtl/keygen_mul_pipe.sv | 155 +++++++++++++++
 tb/tb_keygen_mul_pipe.sv | 253 +++++++++++++++++++++++++
 2 files changed

// File: rtl/keygen_mul_pipe.sv
// Elastic valid/ready pipelined multiplier with a sideband tag for the keygen datapath.
// Build option: define KEYGEN_MUL_SATURATE_EN to clamp results to P_WIDTH and enable sat_flag.
module keygen_mul_pipe #(
    parameter int A_WIDTH   = 17,
    parameter int B_WIDTH   = 16,
    parameter int P_WIDTH   = 32,
    parameter int A_SIGNED  = 1,
    parameter int B_SIGNED  = 0,
    parameter int NUM_STAGE = 4,
    parameter int TAG_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [A_WIDTH-1:0]   din0,
    input  logic [B_WIDTH-1:0]   din1,
    input  logic [TAG_WIDTH-1:0] tag_in,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [P_WIDTH-1:0]   dout,
    output logic [TAG_WIDTH-1:0] tag_out,
    input  logic                 sat_clr,
    output logic                 sat_flag
);

    localparam int FULL_WIDTH = A_WIDTH + B_WIDTH;
    localparam int LAST       = NUM_STAGE - 1;
    localparam bit A_SGN      = (A_SIGNED != 0);
    localparam bit B_SGN      = (B_SIGNED != 0);

    logic [NUM_STAGE-1:0]  v;
    logic [NUM_STAGE-1:0]  rdy;
    logic [NUM_STAGE-1:0]  v_src;
    logic [A_WIDTH-1:0]    a_q;
    logic [B_WIDTH-1:0]    b_q;
    logic [TAG_WIDTH-1:0]  tag_q [NUM_STAGE-1];
    logic [FULL_WIDTH-1:0] a_ext;
    logic [FULL_WIDTH-1:0] b_ext;
    logic [FULL_WIDTH-1:0] mul_full;
    logic [FULL_WIDTH-1:0] prod_last;
    logic [P_WIDTH-1:0]    res_d;

    // A stage is ready when it is empty or every stage after it can advance.
    always_comb begin
        logic acc;
        rdy = '0;
        acc = out_ready;
        for (int k = NUM_STAGE - 1; k >= 0; k--) begin
            acc    = acc | !v[k];
            rdy[k] = acc;
        end
    end

    assign in_ready  = rdy[0];
    assign out_valid = v[LAST];
    assign v_src     = {v[NUM_STAGE-2:0], in_valid};

    // NOTE: state registers use non-blocking assignment so every stage samples pre-edge values.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            v <= '0;
        end else begin
            v <= (rdy & v_src) | (~rdy & v);
        end
    end

    // Extending both operands to the full width keeps the low FULL_WIDTH bits of the
    // modular product exact for every signedness mix.
    assign a_ext    = A_SGN ? {{B_WIDTH{a_q[A_WIDTH-1]}}, a_q} : {{B_WIDTH{1'b0}}, a_q};
    assign b_ext    = B_SGN ? {{A_WIDTH{b_q[B_WIDTH-1]}}, b_q} : {{A_WIDTH{1'b0}}, b_q};
    assign mul_full = a_ext * b_ext;

    // NOTE: interior data registers carry no reset; their content is ignored while v is 0.
    always_ff @(posedge clk) begin
        if (rdy[0]) begin
            a_q      <= din0;
            b_q      <= din1;
            tag_q[0] <= tag_in;
        end
        for (int k = 1; k < NUM_STAGE - 1; k++) begin
            if (rdy[k]) tag_q[k] <= tag_q[k-1];
        end
    end

    if (NUM_STAGE > 2) begin : g_prod
        logic [FULL_WIDTH-1:0] pq [NUM_STAGE-2];

        always_ff @(posedge clk) begin
            if (rdy[1]) pq[0] <= mul_full;
            for (int j = 1; j < NUM_STAGE - 2; j++) begin
                if (rdy[j+1]) pq[j] <= pq[j-1];
            end
        end

        assign prod_last = pq[NUM_STAGE-3];
    end else begin : g_no_prod
        assign prod_last = mul_full;
    end

`ifdef KEYGEN_MUL_SATURATE_EN
    localparam bit RES_SIGNED = A_SGN || B_SGN;

    logic fits;
    logic sat_d;
    logic sat_q;

    always_comb begin
        res_d = prod_last[P_WIDTH-1:0];
        fits  = 1'b1;
        sat_d = 1'b0;
        if (RES_SIGNED) begin
            // In range when all bits from the result sign bit upward agree.
            fits = ((prod_last >> (P_WIDTH - 1)) == '0) ||
                   ((prod_last >> (P_WIDTH - 1)) == ({FULL_WIDTH{1'b1}} >> (P_WIDTH - 1)));
            if (!fits) begin
                res_d = prod_last[FULL_WIDTH-1] ? {1'b1, {(P_WIDTH-1){1'b0}}}
                                                : {1'b0, {(P_WIDTH-1){1'b1}}};
            end
        end else begin
            fits = ((prod_last >> P_WIDTH) == '0);
            if (!fits) res_d = '1;
        end
        sat_d = !fits;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sat_q    <= 1'b0;
            sat_flag <= 1'b0;
        end else begin
            if (rdy[LAST]) sat_q <= sat_d;
            if (out_valid && out_ready && sat_q) sat_flag <= 1'b1;
            else if (sat_clr)                    sat_flag <= 1'b0;
        end
    end
`else
    logic unused_bits;

    assign res_d       = prod_last[P_WIDTH-1:0];
    assign sat_flag    = 1'b0;
    assign unused_bits = ^{sat_clr, prod_last};
`endif

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            dout    <= '0;
            tag_out <= '0;
        end else if (rdy[LAST]) begin
            dout    <= res_d;
            tag_out <= tag_q[LAST-1];
        end
    end

endmodule

// File: tb/tb_keygen_mul_pipe.sv
// Self-checking bench for keygen_mul_pipe: directed cases plus randomized handshake traffic
// compared against an arithmetic reference model and an in-order scoreboard.
module tb_keygen_mul_pipe;

    localparam int A_W = 17;
    localparam int B_W = 16;
    localparam int P_W = 32;
    localparam int NS  = 4;
    localparam int T_W = 8;
    localparam bit A_S = 1'b1;
    localparam bit B_S = 1'b0;

`ifdef KEYGEN_MUL_SATURATE_EN
    localparam logic [P_W-1:0] EXP_BIG = 32'h7FFF_FFFF;
    localparam logic [P_W-1:0] EXP_NEG = 32'h8000_0000;
    localparam logic           EXP_SAT = 1'b1;
`else
    localparam logic [P_W-1:0] EXP_BIG = 32'hFFFE_0001;
    localparam logic [P_W-1:0] EXP_NEG = 32'h0001_0000;
    localparam logic           EXP_SAT = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           reset;
    logic           in_valid;
    logic           in_ready;
    logic [A_W-1:0] din0;
    logic [B_W-1:0] din1;
    logic [T_W-1:0] tag_in;
    logic           out_valid;
    logic           out_ready;
    logic [P_W-1:0] dout;
    logic [T_W-1:0] tag_out;
    logic           sat_clr;
    logic           sat_flag;

    int n_cmp = 0;
    int n_err = 0;

    keygen_mul_pipe dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .din0      (din0),
        .din1      (din1),
        .tag_in    (tag_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .dout      (dout),
        .tag_out   (tag_out),
        .sat_clr   (sat_clr),
        .sat_flag  (sat_flag)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference: true integer product, then wrap or clamp to P_W bits.
    function automatic logic [P_W-1:0] model(input logic [A_W-1:0] a, input logic [B_W-1:0] b);
        longint av, bv, full;
`ifdef KEYGEN_MUL_SATURATE_EN
        longint hi, lo;
`endif
        if (A_S) av = longint'($signed(a)); else av = longint'(a);
        if (B_S) bv = longint'($signed(b)); else bv = longint'(b);
        full = av * bv;
`ifdef KEYGEN_MUL_SATURATE_EN
        if (A_S || B_S) begin
            hi = (64'sd1 <<< (P_W - 1)) - 1;
            lo = -(64'sd1 <<< (P_W - 1));
        end else begin
            hi = (64'sd1 <<< P_W) - 1;
            lo = 0;
        end
        if (full > hi)      full = hi;
        else if (full < lo) full = lo;
`endif
        return full[P_W-1:0];
    endfunction

    logic [P_W+T_W-1:0] sb [$];
    logic [T_W-1:0]     retired [$];
    logic [P_W+T_W-1:0] exp_e;
    logic               prev_stall = 1'b0;
    logic [P_W-1:0]     prev_dout;
    logic [T_W-1:0]     prev_tag;

    // Monitor on the falling edge: handshakes seen here complete at the next rising edge.
    always @(negedge clk) begin
        if (!reset) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall)
                check("stall_hold", {out_valid, tag_out, dout}, {1'b1, prev_tag, prev_dout});
            if (out_valid && out_ready) begin
                check("sb_nonempty", 64'(sb.size() != 0), 64'd1);
                if (sb.size() != 0) begin
                    exp_e = sb.pop_front();
                    check("retire", {tag_out, dout}, exp_e);
                end
                retired.push_back(tag_out);
            end
            if (in_valid && in_ready) sb.push_back({tag_in, model(din0, din1)});
            prev_stall = out_valid && !out_ready;
            prev_dout  = dout;
            prev_tag   = tag_out;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic run_single(input logic [A_W-1:0] a, input logic [B_W-1:0] b,
                              input logic [T_W-1:0] t, input logic [P_W-1:0] exp_d,
                              input logic exp_sat, input string name);
        in_valid  = 1'b1;
        din0      = a;
        din1      = b;
        tag_in    = t;
        out_ready = 1'b1;
        step();
        in_valid = 1'b0;
        for (int i = 0; i <= NS; i++) begin
            if (i > 0) step();
            check({name, "_valid"}, out_valid, 64'(i == NS - 1));
            if (i == NS - 1) begin
                check({name, "_dout"}, dout, exp_d);
                check({name, "_tag"}, tag_out, t);
            end
        end
        check({name, "_sat"}, sat_flag, exp_sat);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish at %0t", $time);
        $fatal(1, "watchdog");
    end

    initial begin
        int  next;
        int  seen;
        logic acc;

        reset = 1'b0; in_valid = 1'b0; din0 = '0; din1 = '0; tag_in = '0;
        out_ready = 1'b0; sat_clr = 1'b0;
        #12;
        check("rst_out_valid", out_valid, 0);
        check("rst_dout", dout, 0);
        check("rst_tag_out", tag_out, 0);
        check("rst_sat_flag", sat_flag, 0);
        check("rst_in_ready", in_ready, 1);
        step();
        reset = 1'b1;
        step();

        run_single(17'h1FFFD, 16'd5, 8'h11, 32'hFFFF_FFF1, 1'b0, "lat");
        run_single(17'h0FFFF, 16'hFFFF, 8'h22, EXP_BIG, EXP_SAT, "big");
        run_single(17'h10000, 16'hFFFF, 8'h33, EXP_NEG, EXP_SAT, "neg");
        sat_clr = 1'b1;
        step();
        sat_clr = 1'b0;
        check("sat_clr", sat_flag, 0);

        // Back-pressure: fill with out_ready low, then release and drain tags 0..9.
        retired.delete();
        out_ready = 1'b0;
        next = 0;
        for (int c = 0; c < 8; c++) begin
            in_valid = 1'b1; din0 = A_W'(next); din1 = 16'd3; tag_in = T_W'(next);
            @(negedge clk);
            acc = in_ready;
            step();
            if (acc) next++;
        end
        check("bp_accepted", next, 4);
        check("bp_in_ready", in_ready, 0);
        check("bp_out_valid", out_valid, 1);
        out_ready = 1'b1;
        #1;
        check("bp_release_in_ready", in_ready, 1);
        for (int c = 0; c < 40 && retired.size() < 10; c++) begin
            in_valid = (next < 10); din0 = A_W'(next); din1 = 16'd3; tag_in = T_W'(next);
            @(negedge clk);
            acc = in_ready && in_valid;
            step();
            if (acc) next++;
        end
        in_valid = 1'b0;
        check("bp_retired_count", retired.size(), 10);
        for (int i = 0; i < 10 && i < retired.size(); i++) check("bp_order", retired[i], i);

        // Randomized traffic; the monitor checks every retire and every stall.
        for (int c = 0; c < 10000; c++) begin
            in_valid  = ($urandom_range(0, 3) != 0);
            out_ready = ($urandom_range(0, 2) != 0);
            case ($urandom_range(0, 3))
                0:       din0 = 17'h10000;
                1:       din0 = 17'h0FFFF;
                default: din0 = A_W'($urandom);
            endcase
            din1    = ($urandom_range(0, 3) == 0) ? 16'hFFFF : B_W'($urandom);
            tag_in  = T_W'($urandom);
            sat_clr = ($urandom_range(0, 15) == 0);
            step();
        end
        in_valid = 1'b0; out_ready = 1'b1; sat_clr = 1'b0;
        for (int c = 0; c < 20 && sb.size() != 0; c++) step();
        check("drain_empty", sb.size(), 0);

        // Reset with three results in flight.
        out_ready = 1'b0;
        for (int c = 0; c < 3; c++) begin
            in_valid = 1'b1; din0 = A_W'(c + 1); din1 = 16'd7; tag_in = T_W'(c + 8'h40);
            step();
        end
        in_valid = 1'b0;
        step();
        check("pre_rst_out_valid", out_valid, 1);
        #2;
        reset = 1'b0;
        #1;
        check("midrst_out_valid", out_valid, 0);
        check("midrst_in_ready", in_ready, 1);
        check("midrst_dout", dout, 0);
        sb.delete();
        step();
        step();
        reset = 1'b1;
        out_ready = 1'b1;
        seen = 0;
        for (int c = 0; c < 10; c++) begin
            step();
            if (out_valid) seen++;
        end
        check("no_stale_results", seen, 0);
        check("post_rst_in_ready", in_ready, 1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
